// File: rtl/result_uart_tx.sv
// Result frame UART transmitter: sends result_data, then {7'b0, overflow}, as two
// back-to-back 8N1 bytes. tx/busy/done are registered.
`timescale 1ns/1ps
module result_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] result_data,
  input  logic       overflow,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START_BIT, DATA_BITS, STOP_BIT} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic          byte_idx, byte_idx_n;
  logic [7:0]    data_q, data_n;
  logic          ovf_q, ovf_n;
  logic [7:0]    shift_q, shift_n;
  logic          tx_n, busy_n, done_n;
  logic          bit_end;
  logic [7:0]    cur_byte;

  assign bit_end  = (cnt == LAST_CNT);
  assign cur_byte = byte_idx ? {7'b0, ovf_q} : data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      byte_idx <= 1'b0;
      data_q   <= '0;
      ovf_q    <= 1'b0;
      shift_q  <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bit_idx  <= bit_idx_n;
      byte_idx <= byte_idx_n;
      data_q   <= data_n;
      ovf_q    <= ovf_n;
      shift_q  <= shift_n;
      tx       <= tx_n;
      busy     <= busy_n;
      done     <= done_n;
    end
  end

  // Outputs are computed for the cycle after the edge so they leave straight from flops.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    bit_idx_n  = bit_idx;
    byte_idx_n = byte_idx;
    data_n     = data_q;
    ovf_n      = ovf_q;
    shift_n    = shift_q;
    tx_n       = tx;
    busy_n     = busy;
    done_n     = 1'b0;

    case (state)
      IDLE: begin
        tx_n   = 1'b1;
        busy_n = 1'b0;
        if (start) begin
          data_n     = result_data;
          ovf_n      = overflow;
          byte_idx_n = 1'b0;
          cnt_n      = '0;
          state_n    = START_BIT;
          tx_n       = 1'b0;
          busy_n     = 1'b1;
        end
      end

      START_BIT: begin
        if (bit_end) begin
          cnt_n     = '0;
          bit_idx_n = '0;
          shift_n   = cur_byte;
          tx_n      = cur_byte[0];
          state_n   = DATA_BITS;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      DATA_BITS: begin
        if (bit_end) begin
          cnt_n = '0;
          if (bit_idx == 3'd7) begin
            state_n = STOP_BIT;
            tx_n    = 1'b1;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
            shift_n   = {1'b0, shift_q[7:1]};
            tx_n      = shift_q[1];
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      STOP_BIT: begin
        if (bit_end) begin
          cnt_n = '0;
          if (!byte_idx) begin
            byte_idx_n = 1'b1;
            state_n    = START_BIT;
            tx_n       = 1'b0;
          end else begin
            byte_idx_n = 1'b0;
            state_n    = IDLE;
            tx_n       = 1'b1;
            busy_n     = 1'b0;
            done_n     = 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_result_uart_tx.sv
// Self-checking bench for result_uart_tx at CLKS_PER_BIT=4: per-cycle tx/busy/done
// against a bit-position model, plus a mid-bit sampling receiver.
`timescale 1ns/1ps
module tb_result_uart_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst, start, overflow;
  logic [7:0] result_data;
  logic       tx, busy, done;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  result_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .start(start), .result_data(result_data),
    .overflow(overflow), .tx(tx), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected line level n cycles (0-based) into a 20-bit two-byte frame.
  function automatic logic exp_tx(input logic [7:0] d, input logic ovf, input int n);
    int bitpos;
    int b;
    logic [7:0] by;
    bitpos = n / CPB;
    b      = bitpos % 10;
    by     = (bitpos < 10) ? d : {7'b0, ovf};
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return by[b-1];
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_tx"},   tx,   1'b1);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
  endtask

  // Caller is at a negedge with the block idle (or in its done cycle).
  // keep: hold start high through the frame; noise: scramble data and re-pulse start.
  task automatic frame_check(input logic [7:0] d, input logic ovf, input bit keep, input bit noise);
    logic [7:0] rx0, rx1;
    int bitpos, b;
    rx0 = '0;
    rx1 = '0;
    start = 1'b1;
    result_data = d;
    overflow = ovf;
    for (int n = 1; n <= 20 * CPB; n++) begin
      @(negedge clk);
      chk("frame_tx",   tx,   exp_tx(d, ovf, n - 1));
      chk("frame_busy", busy, 1'b1);
      chk("frame_done", done, 1'b0);
      bitpos = (n - 1) / CPB;
      b      = bitpos % 10;
      if (((n - 1) % CPB) == CPB / 2 && b >= 1 && b <= 8) begin
        if (bitpos < 10) rx0[b-1] = tx;
        else             rx1[b-1] = tx;
      end
      start = keep;
      if (noise) begin
        result_data = 8'($urandom);
        overflow    = ~ovf;
        if (n == 10 || n == 50) start = 1'b1;
      end
    end
    @(negedge clk);
    chk("done_pulse", done, 1'b1);
    chk("done_tx",    tx,   1'b1);
    chk("done_busy",  busy, 1'b0);
    chk("rx_byte0",   rx0,  d);
    chk("rx_byte1",   rx1,  {7'b0, ovf});
    start = 1'b0;
  endtask

  initial begin
    logic [7:0] rd;
    logic       ro;
    rst = 1'b1;
    start = 1'b0;
    result_data = '0;
    overflow = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle("reset");
    rst = 1'b0;
    @(negedge clk);
    chk_idle("post_reset");

    frame_check(8'hA5, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk_idle("after_a5");

    frame_check(8'hFF, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk_idle("after_ff");

    frame_check(8'h3C, 1'b0, 1'b0, 1'b1);
    repeat (3) begin
      @(negedge clk);
      chk_idle("after_noise");
    end

    // Reset at cycle 30 of a frame.
    start = 1'b1;
    result_data = 8'h5A;
    overflow = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      start = 1'b0;
      chk("midrst_tx", tx, exp_tx(8'h5A, 1'b1, n - 1));
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_idle("midrst_next");
    repeat (90) begin
      @(negedge clk);
      chk_idle("midrst_quiet");
    end
    rd = 8'($urandom);
    ro = 1'($urandom);
    frame_check(rd, ro, 1'b0, 1'b0);
    @(negedge clk);
    chk_idle("after_midrst_frame");

    // rst and start at the same edge.
    rst = 1'b1;
    start = 1'b1;
    result_data = 8'h81;
    @(negedge clk);
    chk_idle("rst_start");
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk_idle("rst_start_after");

    // Back-to-back frames with start held high.
    for (int i = 0; i < 3; i++) begin
      rd = 8'($urandom);
      ro = 1'($urandom);
      frame_check(rd, ro, (i < 2), 1'b0);
    end
    @(negedge clk);
    chk_idle("after_b2b");

    for (int i = 0; i < 4; i++) begin
      rd = 8'($urandom);
      ro = 1'($urandom);
      frame_check(rd, ro, 1'b0, (i % 2) == 1);
      @(negedge clk);
      chk_idle("after_rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
